// File: rtl/contador_pkg.sv
// contador_pkg: shared types and constants for the programmable-modulus
// counter / clock divider (contador_prog).
//   cont_state_t : counter state, ST_RUN (counting) / ST_DONE (one-shot finished)
//   DIR_*        : encoding of the dir input
//   MODE_*       : encoding of the mode input
package contador_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cont_state_t;

  localparam logic DIR_DOWN    = 1'b0;
  localparam logic DIR_UP      = 1'b1;
  localparam logic MODE_FREE   = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/contador_prog.sv
// contador_prog: programmable-modulus up/down counter and clock divider.
// Counts modulo (modulo+1), emits a one-cycle terminal-count pulse and a
// 50% duty divided clock that toggles on every wrap. Supports free-running
// and one-shot operation.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   en         : count enable
//   load       : synchronous load strobe (highest priority)
//   load_val   : value to load, clamped to modulo
//   modulo     : terminal value, period is modulo+1
//   dir        : 1 = up, 0 = down
//   mode       : 0 = free-running, 1 = one-shot
//   cont       : current count (registered)
//   tc         : terminal-count pulse (registered)
//   clk_div    : divided clock (registered)
//   done       : one-shot finished (registered)
module contador_prog
  import contador_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic [SIZE-1:0] modulo,
  input  logic            dir,
  input  logic            mode,
  output logic [SIZE-1:0] cont,
  output logic            tc,
  output logic            clk_div,
  output logic            done
);

  cont_state_t     r_state;
  logic [SIZE-1:0] r_cont;
  logic            r_tc;
  logic            r_div;
  logic            r_done;

  cont_state_t     w_state_nxt;
  logic [SIZE-1:0] w_cont_nxt;
  logic            w_tc_nxt;
  logic            w_div_nxt;
  logic            w_done_nxt;
  logic            w_term;

  // Up uses >= so a modulo lowered below the current count wraps on the next
  // enabled edge instead of running off to 2^SIZE.
  assign w_term = (dir == DIR_UP) ? (r_cont >= modulo) : (r_cont == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cont_nxt  = r_cont;
    w_tc_nxt    = 1'b0;
    w_div_nxt   = r_div;
    w_done_nxt  = r_done;
    if (load) begin
      w_cont_nxt  = (load_val > modulo) ? modulo : load_val;
      w_state_nxt = ST_RUN;
      w_done_nxt  = 1'b0;
    end else if (r_state == ST_RUN && en) begin
      if (!w_term) begin
        w_cont_nxt = (dir == DIR_UP) ? r_cont + 1'b1 : r_cont - 1'b1;
      end else begin
        w_tc_nxt  = 1'b1;
        w_div_nxt = ~r_div;
        if (mode == MODE_ONESHOT) begin
          // Count freezes on the terminal value until the next load.
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cont_nxt = (dir == DIR_UP) ? '0 : modulo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cont  <= '0;
      r_tc    <= 1'b0;
      r_div   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cont  <= w_cont_nxt;
      r_tc    <= w_tc_nxt;
      r_div   <= w_div_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign cont    = r_cont;
  assign tc      = r_tc;
  assign clk_div = r_div;
  assign done    = r_done;

endmodule

// File: tb/tb_contador_prog.sv
// Self-checking bench for contador_prog (SIZE=4): a directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural reference model.
module tb_contador_prog;

  localparam int SIZE = 4;
  localparam int MAXV = (1 << SIZE) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [SIZE-1:0] load_val = '0;
  logic [SIZE-1:0] modulo = '0;
  logic            dir = 1'b1;
  logic            mode = 1'b0;
  logic [SIZE-1:0] cont;
  logic            tc;
  logic            clk_div;
  logic            done;

  int total = 0;
  int bad   = 0;

  contador_prog #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .modulo(modulo), .dir(dir), .mode(mode),
    .cont(cont), .tc(tc), .clk_div(clk_div), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, one call per clock edge.
  int  m_cont, m_tc, m_div, m_done;
  bit  m_fin;

  task automatic m_reset();
    m_cont = 0; m_tc = 0; m_div = 0; m_done = 0; m_fin = 0;
  endtask

  task automatic m_step(input int i_en, input int i_load, input int i_lv,
                        input int i_mod, input int i_dir, input int i_mode);
    bit at_end;
    m_tc = 0;
    if (i_load != 0) begin
      m_cont = (i_lv < i_mod) ? i_lv : i_mod;
      m_fin  = 0;
      m_done = 0;
    end else if (!m_fin && i_en != 0) begin
      at_end = (i_dir != 0) ? (m_cont >= i_mod) : (m_cont == 0);
      if (!at_end) begin
        m_cont = (i_dir != 0) ? (m_cont + 1) % (MAXV + 1) : m_cont - 1;
      end else begin
        m_tc  = 1;
        m_div = 1 - m_div;
        if (i_mode != 0) begin
          m_fin  = 1;
          m_done = 1;
        end else begin
          m_cont = (i_dir != 0) ? 0 : i_mod;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int i_en, input int i_load, input int i_lv,
                       input int i_mod, input int i_dir, input int i_mode);
    en       = (i_en != 0);
    load     = (i_load != 0);
    load_val = SIZE'(i_lv);
    modulo   = SIZE'(i_mod);
    dir      = (i_dir != 0);
    mode     = (i_mode != 0);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    #1;
    chk("rst_cont", int'(cont), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_div", int'(clk_div), 0);
    chk("rst_done", int'(done), 0);
    edge_wait();
    rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    int en, load, lv, mod, dir, mode;
    int e_cont, e_tc, e_div, e_done;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int ntc, ndiv, prev_div;

    tbl[0]  = '{1,0,0,4,1,0, 1,0,0,0};
    tbl[1]  = '{1,0,0,4,1,0, 2,0,0,0};
    tbl[2]  = '{1,0,0,4,1,0, 3,0,0,0};
    tbl[3]  = '{1,0,0,4,1,0, 4,0,0,0};
    tbl[4]  = '{1,0,0,4,1,0, 0,1,1,0};
    tbl[5]  = '{1,0,0,4,1,0, 1,0,1,0};
    tbl[6]  = '{1,1,9,5,1,0, 5,0,1,0};  // load clamps to modulo
    tbl[7]  = '{1,1,9,5,1,0, 5,0,1,0};  // load on terminal cycle: no tc/toggle
    tbl[8]  = '{1,0,0,5,1,0, 0,1,0,0};
    tbl[9]  = '{0,0,0,5,1,0, 0,0,0,0};
    tbl[10] = '{1,0,0,0,1,0, 0,1,1,0};  // modulo=0: every cycle terminal
    tbl[11] = '{1,0,0,0,1,0, 0,1,0,0};
    tbl[12] = '{0,0,0,0,1,0, 0,0,0,0};
    tbl[13] = '{1,0,0,4,0,0, 4,1,1,0};  // down from 0 wraps to modulo
    tbl[14] = '{1,0,0,4,0,0, 3,0,1,0};
    tbl[15] = '{1,0,0,1,1,0, 0,1,0,0};  // modulo lowered below cont, up
    tbl[16] = '{1,0,0,2,1,1, 1,0,0,0};
    tbl[17] = '{1,0,0,2,1,1, 2,0,0,0};
    tbl[18] = '{1,0,0,2,1,1, 2,1,1,1};  // one-shot terminal
    tbl[19] = '{1,0,0,2,1,1, 2,0,1,1};
    tbl[20] = '{0,0,0,2,1,1, 2,0,1,1};
    tbl[21] = '{1,1,1,2,1,1, 1,0,1,0};  // load releases one-shot
    tbl[22] = '{1,0,0,2,1,1, 2,0,1,0};

    // Directed table
    do_reset();
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].en, tbl[i].load, tbl[i].lv, tbl[i].mod, tbl[i].dir, tbl[i].mode);
      edge_wait();
      chk($sformatf("tbl%0d_cont", i), int'(cont), tbl[i].e_cont);
      chk($sformatf("tbl%0d_tc", i), int'(tc), tbl[i].e_tc);
      chk($sformatf("tbl%0d_div", i), int'(clk_div), tbl[i].e_div);
      chk($sformatf("tbl%0d_done", i), int'(done), tbl[i].e_done);
    end

    // Free-run periods: modulo=4 for 20 edges -> 4 tc pulses, 4 toggles,
    // each tc coinciding with a clk_div transition.
    do_reset();
    ntc = 0; ndiv = 0; prev_div = 0;
    drive(1, 0, 0, 4, 1, 0);
    for (int i = 0; i < 20; i++) begin
      edge_wait();
      if (tc) ntc++;
      if (int'(clk_div) != prev_div) ndiv++;
      chk("tc_with_div_edge", int'(tc), (int'(clk_div) != prev_div) ? 1 : 0);
      prev_div = int'(clk_div);
    end
    chk("freerun_tc_count", ntc, 4);
    chk("freerun_div_toggles", ndiv, 4);

    // One-shot: single pulse, en toggling ignored while done.
    do_reset();
    ntc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i % 3 != 2, 0, 0, 3, 1, 1);
      edge_wait();
      if (tc) ntc++;
    end
    chk("oneshot_pulses", ntc, 1);
    chk("oneshot_cont", int'(cont), 3);
    chk("oneshot_done", int'(done), 1);

    // Asynchronous reset mid-count with cont=3, clk_div=1.
    do_reset();
    drive(1, 0, 0, 4, 1, 0);
    for (int i = 0; i < 8; i++) edge_wait();
    chk("pre_rst_cont", int'(cont), 3);
    chk("pre_rst_div", int'(clk_div), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cont", int'(cont), 0);
    chk("async_rst_div", int'(clk_div), 0);
    chk("async_rst_tc", int'(tc), 0);
    #1;
    rst_n = 1'b1;
    edge_wait();
    chk("post_rst_cont", int'(cont), 1);
    chk("post_rst_tc", int'(tc), 0);

    // Randomized run against the reference model.
    do_reset();
    begin
      int r_mod, r_dir, r_mode;
      r_mod = 5; r_dir = 1; r_mode = 0;
      for (int i = 0; i < 3000; i++) begin
        int r_en, r_load, r_lv;
        if ($urandom_range(0, 19) == 0) r_mod = $urandom_range(0, MAXV);
        if ($urandom_range(0, 9) == 0) r_dir = $urandom_range(0, 1);
        if ($urandom_range(0, 29) == 0) r_mode = $urandom_range(0, 1);
        r_en   = ($urandom_range(0, 3) != 0);
        r_load = ($urandom_range(0, 15) == 0);
        r_lv   = $urandom_range(0, MAXV);
        drive(r_en, r_load, r_lv, r_mod, r_dir, r_mode);
        edge_wait();
        m_step(r_en, r_load, r_lv, r_mod, r_dir, r_mode);
        chk("rnd_cont", int'(cont), m_cont);
        chk("rnd_tc", int'(tc), m_tc);
        chk("rnd_div", int'(clk_div), m_div);
        chk("rnd_done", int'(done), m_done);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
